// File: rtl/voice_allocator_pkg.sv
// rtl/voice_allocator_pkg.sv - shared FSM state, param_data field offsets and octave-10 delta_phase table
package voice_allocator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_STEAL,
    ST_WAIT_GRANT,
    ST_WRITE
  } state_e;

  localparam int PARAM_W  = 37;
  localparam int GATE_BIT = 36;
  localparam int WAVE_MSB = 35;
  localparam int WAVE_LSB = 32;

  // round(f * 2^32 / 48000) for MIDI notes 120..131 (C..B, octave 10)
  localparam logic [31:0] DPHASE_OCT10 [12] = '{
    32'd749115498,  32'd793660223,  32'd840853717,  32'd890853481,
    32'd943826385,  32'd999949222,  32'd1059409297, 32'd1122405052,
    32'd1189146729, 32'd1259857073, 32'd1334772074, 32'd1414141751
  };

endpackage

// File: rtl/note_to_delta_phase.sv
// rtl/note_to_delta_phase.sv - combinational MIDI note to 32-bit phase increment
module note_to_delta_phase
  import voice_allocator_pkg::*;
(
  input  logic [6:0]  note_i,
  input  logic [31:0] unused_pad_i,
  output logic [31:0] delta_phase_o
);

  logic [3:0] oct;
  logic [3:0] semi;
  logic [3:0] shamt;

  assign oct   = 4'(note_i / 7'd12);
  assign semi  = 4'(note_i % 7'd12);
  // notes 120..127 sit in octave 10 and take the table value unshifted
  assign shamt = 4'd10 - oct;

  assign delta_phase_o = DPHASE_OCT10[semi] >> shamt;

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - MIDI note event to voice parameter RAM allocator
// VOICE_ALLOCATOR_STEAL_EN: when defined, a note-on with no free voice steals the oldest voice.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ev_valid,
  output logic                ev_ready,
  input  logic                ev_note_on,
  input  logic [6:0]          ev_note,
  input  logic [3:0]          ev_wave,
  input  logic                wr_grant,
  output logic                param_we,
  output logic [7:0]          param_addr,
  output logic [PARAM_W-1:0]  param_data,
  output logic [8:0]          voices_active,
  output logic                ev_dropped
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

  state_e               state_q;
  logic [IW-1:0]        idx_q, sel_q;
  logic                 on_q;
  logic [6:0]           note_q;
  logic [3:0]           wave_q;
  logic                 param_we_q, dropped_q;
  logic [7:0]           param_addr_q;
  logic [PARAM_W-1:0]   param_data_q;
`ifdef VOICE_ALLOCATOR_STEAL_EN
  logic [7:0]           best_age_q;
`endif

  logic [NUM_VOICES-1:0] busy_q, busy_d;
  logic [6:0]            tag_q [NUM_VOICES];
  logic [6:0]            tag_d [NUM_VOICES];
  logic [7:0]            age_q [NUM_VOICES];
  logic [7:0]            age_d [NUM_VOICES];
  logic [8:0]            active_q, active_d;

  logic                  voice_hit;
  logic [31:0]           dphase;
  logic [PARAM_W-1:0]    wr_data;

  note_to_delta_phase u_dphase (
    .note_i        (note_q),
    .unused_pad_i  (32'd0),
    .delta_phase_o (dphase)
  );

  assign ev_ready      = (state_q == ST_IDLE) && !reset;
  assign param_we      = param_we_q;
  assign param_addr    = param_addr_q;
  assign param_data    = param_data_q;
  assign voices_active = active_q;
  assign ev_dropped    = dropped_q;

  always_comb begin
    voice_hit = on_q ? !busy_q[idx_q] : (busy_q[idx_q] && (tag_q[idx_q] == note_q));
  end

  always_comb begin
    wr_data = '0;
    if (on_q) begin
      wr_data[GATE_BIT]          = 1'b1;
      wr_data[WAVE_MSB:WAVE_LSB] = wave_q;
      wr_data[WAVE_LSB-1:0]      = dphase;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      sel_q        <= '0;
      on_q         <= 1'b0;
      note_q       <= '0;
      wave_q       <= '0;
      param_we_q   <= 1'b0;
      param_addr_q <= '0;
      param_data_q <= '0;
      dropped_q    <= 1'b0;
`ifdef VOICE_ALLOCATOR_STEAL_EN
      best_age_q   <= '0;
`endif
    end else begin
      param_we_q <= 1'b0;
      dropped_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ev_valid) begin
            on_q    <= ev_note_on;
            note_q  <= ev_note;
            wave_q  <= ev_wave;
            idx_q   <= '0;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (voice_hit) begin
            sel_q   <= idx_q;
            state_q <= ST_WAIT_GRANT;
          end else if (idx_q == LAST) begin
`ifdef VOICE_ALLOCATOR_STEAL_EN
            if (on_q) begin
              idx_q      <= '0;
              sel_q      <= '0;
              best_age_q <= '0;
              state_q    <= ST_STEAL;
            end else begin
              dropped_q <= 1'b1;
              state_q   <= ST_IDLE;
            end
`else
            dropped_q <= 1'b1;
            state_q   <= ST_IDLE;
`endif
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_STEAL: begin
`ifdef VOICE_ALLOCATOR_STEAL_EN
          // strict compare keeps the lowest index on equal ages
          if (age_q[idx_q] > best_age_q) begin
            best_age_q <= age_q[idx_q];
            sel_q      <= idx_q;
          end
          if (idx_q == LAST) state_q <= ST_WAIT_GRANT;
          else               idx_q   <= idx_q + 1'b1;
`else
          state_q <= ST_IDLE;
`endif
        end
        ST_WAIT_GRANT: begin
          if (wr_grant) begin
            param_we_q   <= 1'b1;
            param_addr_q <= 8'(sel_q);
            param_data_q <= wr_data;
            state_q      <= ST_WRITE;
          end
        end
        ST_WRITE: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    age_d  = age_q;
    if (state_q == ST_WRITE) begin
      if (on_q) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (busy_q[i] && (age_q[i] != 8'hff)) age_d[i] = age_q[i] + 8'd1;
        end
        busy_d[sel_q] = 1'b1;
        tag_d[sel_q]  = note_q;
        age_d[sel_q]  = 8'd0;
      end else begin
        busy_d[sel_q] = 1'b0;
        age_d[sel_q]  = 8'd0;
      end
    end
    active_d = '0;
    for (int i = 0; i < NUM_VOICES; i++) active_d = active_d + 9'(busy_d[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= '0;
      active_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        tag_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      busy_q   <= busy_d;
      tag_q    <= tag_d;
      age_q    <= age_d;
      active_q <= active_d;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed self-checking bench for voice_allocator
module tb_voice_allocator;

  localparam int NV = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic        ev_note_on = 1'b0;
  logic [6:0]  ev_note = '0;
  logic [3:0]  ev_wave = '0;
  logic        wr_grant = 1'b0;
  logic        param_we;
  logic [7:0]  param_addr;
  logic [36:0] param_data;
  logic [8:0]  voices_active;
  logic        ev_dropped;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int drop_cnt = 0;
  logic [7:0]  last_addr = '0;
  logic [36:0] last_data = '0;

  always #5 clk = ~clk;

  voice_allocator #(.NUM_VOICES(NV)) dut (
    .clk           (clk),
    .reset         (reset),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_note_on    (ev_note_on),
    .ev_note       (ev_note),
    .ev_wave       (ev_wave),
    .wr_grant      (wr_grant),
    .param_we      (param_we),
    .param_addr    (param_addr),
    .param_data    (param_data),
    .voices_active (voices_active),
    .ev_dropped    (ev_dropped)
  );

  always @(negedge clk) begin
    if (param_we === 1'b1) begin
      we_cnt    = we_cnt + 1;
      last_addr = param_addr;
      last_data = param_data;
    end
    if (ev_dropped === 1'b1) drop_cnt = drop_cnt + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    ev_valid = 1'b0;
    wr_grant = 1'b0;
    reset    = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
  endtask

  task automatic send_event(input logic on, input logic [6:0] n, input logic [3:0] w);
    @(negedge clk);
    ev_valid   = 1'b1;
    ev_note_on = on;
    ev_note    = n;
    ev_wave    = w;
    for (int i = 0; i < 4 * NV; i++) begin
      if (ev_ready === 1'b1) begin
        @(negedge clk);
        ev_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    ev_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL send_event: ev_ready=%b, required 1 within %0d cycles", ev_ready, 4 * NV);
  endtask

  task automatic pulse_grant;
    @(negedge clk);
    wr_grant = 1'b1;
    @(negedge clk);
    wr_grant = 1'b0;
  endtask

  task automatic note_on_full(input logic [6:0] n, input logic [3:0] w);
    send_event(1'b1, n, w);
    idle(2 * NV + 4);
    pulse_grant();
    idle(1);
  endtask

  task automatic test_reset;
    idle(2);
    checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL reset_ev_ready: got %b want 0", ev_ready); end
    checks++; if (param_we !== 1'b0) begin errors++; $display("FAIL reset_param_we: got %b want 0", param_we); end
    checks++; if (param_addr !== 8'd0) begin errors++; $display("FAIL reset_param_addr: got %0d want 0", param_addr); end
    checks++; if (param_data !== 37'd0) begin errors++; $display("FAIL reset_param_data: got %h want 0", param_data); end
    checks++; if (voices_active !== 9'd0) begin errors++; $display("FAIL reset_voices_active: got %0d want 0", voices_active); end
    checks++; if (ev_dropped !== 1'b0) begin errors++; $display("FAIL reset_ev_dropped: got %b want 0", ev_dropped); end
    reset = 1'b0;
    idle(1);
    checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL idle_ev_ready: got %b want 1", ev_ready); end
  endtask

  task automatic test_single_note_on;
    int base;
    do_reset();
    base = we_cnt;
    send_event(1'b1, 7'd69, 4'd2);
    idle(5);
    checks++; if (we_cnt !== base) begin errors++; $display("FAIL single_no_early_write: got %0d writes want 0", we_cnt - base); end
    pulse_grant();
    idle(1);
    checks++; if (we_cnt - base !== 1) begin errors++; $display("FAIL single_write_count: got %0d want 1", we_cnt - base); end
    checks++; if (last_addr !== 8'd0) begin errors++; $display("FAIL single_addr: got %0d want 0", last_addr); end
    checks++; if (last_data !== {1'b1, 4'd2, 32'd39370533}) begin errors++; $display("FAIL single_data: got %h want %h", last_data, {1'b1, 4'd2, 32'd39370533}); end
    checks++; if (voices_active !== 9'd1) begin errors++; $display("FAIL single_voices: got %0d want 1", voices_active); end
  endtask

  task automatic test_on_off;
    int base;
    do_reset();
    base = we_cnt;
    note_on_full(7'd60, 4'd1);
    checks++; if (last_addr !== 8'd0 || last_data !== {1'b1, 4'd1, 32'd23409859}) begin errors++; $display("FAIL on60: got addr %0d data %h want addr 0 data %h", last_addr, last_data, {1'b1, 4'd1, 32'd23409859}); end
    note_on_full(7'd64, 4'd3);
    checks++; if (last_addr !== 8'd1 || last_data !== {1'b1, 4'd3, 32'd29494574}) begin errors++; $display("FAIL on64: got addr %0d data %h want addr 1 data %h", last_addr, last_data, {1'b1, 4'd3, 32'd29494574}); end
    checks++; if (voices_active !== 9'd2) begin errors++; $display("FAIL on_off_voices2: got %0d want 2", voices_active); end
    send_event(1'b0, 7'd60, 4'd7);
    idle(2 * NV + 4);
    pulse_grant();
    idle(1);
    checks++; if (last_addr !== 8'd0 || last_data !== 37'd0) begin errors++; $display("FAIL off60: got addr %0d data %h want addr 0 data 0", last_addr, last_data); end
    checks++; if (voices_active !== 9'd1) begin errors++; $display("FAIL on_off_voices1: got %0d want 1", voices_active); end
    checks++; if (we_cnt - base !== 3) begin errors++; $display("FAIL on_off_writes: got %0d want 3", we_cnt - base); end
  endtask

  task automatic test_off_miss;
    int base_we, base_drop;
    bit ready_seen;
    base_we = we_cnt;
    base_drop = drop_cnt;
    ready_seen = 1'b0;
    send_event(1'b0, 7'd50, 4'd0);
    for (int i = 0; i < NV + 1; i++) begin
      @(negedge clk);
      if (ev_ready === 1'b1) begin
        ready_seen = 1'b1;
        break;
      end
    end
    idle(3);
    checks++; if (!ready_seen) begin errors++; $display("FAIL miss_ready: got ev_ready=%b want 1 within %0d cycles", ev_ready, NV + 1); end
    checks++; if (drop_cnt - base_drop !== 1) begin errors++; $display("FAIL miss_dropped: got %0d pulses want 1", drop_cnt - base_drop); end
    checks++; if (we_cnt !== base_we) begin errors++; $display("FAIL miss_no_write: got %0d writes want 0", we_cnt - base_we); end
  endtask

  task automatic test_overflow;
    int base_we, base_drop;
    do_reset();
    for (int i = 0; i < NV; i++) note_on_full(7'(40 + i), 4'd1);
    checks++; if (voices_active !== 9'd16) begin errors++; $display("FAIL full_voices: got %0d want 16", voices_active); end
    base_we = we_cnt;
    base_drop = drop_cnt;
`ifdef VOICE_ALLOCATOR_STEAL_EN
    note_on_full(7'd56, 4'd9);
    checks++; if (we_cnt - base_we !== 1) begin errors++; $display("FAIL steal_writes: got %0d want 1", we_cnt - base_we); end
    checks++; if (last_addr !== 8'd0 || last_data !== {1'b1, 4'd9, 32'd18580417}) begin errors++; $display("FAIL steal_target: got addr %0d data %h want addr 0 data %h", last_addr, last_data, {1'b1, 4'd9, 32'd18580417}); end
    checks++; if (drop_cnt !== base_drop) begin errors++; $display("FAIL steal_no_drop: got %0d want 0", drop_cnt - base_drop); end
`else
    send_event(1'b1, 7'd56, 4'd9);
    idle(2 * NV + 4);
    checks++; if (drop_cnt - base_drop !== 1) begin errors++; $display("FAIL overflow_dropped: got %0d want 1", drop_cnt - base_drop); end
    checks++; if (we_cnt !== base_we) begin errors++; $display("FAIL overflow_no_write: got %0d want 0", we_cnt - base_we); end
`endif
    checks++; if (voices_active !== 9'd16) begin errors++; $display("FAIL overflow_voices: got %0d want 16", voices_active); end
  endtask

  task automatic test_stray_grant;
    int base;
    do_reset();
    base = we_cnt;
    pulse_grant();
    idle(2);
    checks++; if (we_cnt !== base) begin errors++; $display("FAIL stray_idle_grant: got %0d writes want 0", we_cnt - base); end
    send_event(1'b1, 7'd72, 4'd5);
    idle(10);
    checks++; if (we_cnt !== base) begin errors++; $display("FAIL stray_wait_for_grant: got %0d writes want 0", we_cnt - base); end
    pulse_grant();
    idle(10);
    checks++; if (we_cnt - base !== 1) begin errors++; $display("FAIL stray_one_write: got %0d want 1", we_cnt - base); end
    checks++; if (last_addr !== 8'd0 || last_data !== {1'b1, 4'd5, 32'd46819718}) begin errors++; $display("FAIL stray_data: got addr %0d data %h want addr 0 data %h", last_addr, last_data, {1'b1, 4'd5, 32'd46819718}); end
  endtask

  task automatic test_reset_in_wait;
    int base;
    do_reset();
    note_on_full(7'd62, 4'd1);
    base = we_cnt;
    send_event(1'b1, 7'd63, 4'd1);
    idle(5);
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    checks++; if (voices_active !== 9'd0) begin errors++; $display("FAIL rst_wait_voices: got %0d want 0", voices_active); end
    reset = 1'b0;
    pulse_grant();
    idle(3);
    checks++; if (we_cnt !== base) begin errors++; $display("FAIL rst_wait_no_write: got %0d writes want 0", we_cnt - base); end
    note_on_full(7'd65, 4'd4);
    checks++; if (last_addr !== 8'd0) begin errors++; $display("FAIL rst_wait_next_addr: got %0d want 0", last_addr); end
    checks++; if (voices_active !== 9'd1) begin errors++; $display("FAIL rst_wait_next_voices: got %0d want 1", voices_active); end
  endtask

  initial begin
    test_reset();
    test_single_note_on();
    test_on_off();
    test_off_miss();
    test_overflow();
    test_stray_grant();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 16, giving the number of allocatable voices (2..256), mapped to parameter RAM addresses 0..NUM_VOICES-1.
REQ-002 SHALL have the following ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- ev_valid  in  1  a MIDI note event is offered.
- ev_ready  out  1  the allocator accepts the event on this cycle when ev_valid=1.
- ev_note_on  in  1  1 = note-on, 0 = note-off.
- ev_note  in  7  MIDI note number 0..127.
- ev_wave  in  4  wave_select value for a note-on.
- wr_grant  in  1  single-cycle pulse from the voice sequencer marking the parameter-update window.
- param_we  out  1  parameter RAM write enable.
- param_addr  out  8  RAM address, i.e. voice index.
- param_data  out  37  {gate[36], wave_select[35:32], delta_phase[31:0]}.
- voices_active  out  9  count of gated voices.
- ev_dropped  out  1  one-cycle pulse when an event is discarded.

Function
REQ-003 SHALL keep per-voice state: busy bit, 7-bit note tag, and 8-bit age stamp.
REQ-004 SHALL implement the FSM IDLE -> SCAN -> WAIT_GRANT -> WRITE -> IDLE.
REQ-005 ev_ready SHALL be 1 only in IDLE; an event SHALL be accepted on the edge where ev_valid=ev_ready=1, latching note, wave and on/off, then entering SCAN.
REQ-006 In SCAN, exactly one voice index SHALL be examined per cycle, starting from 0.
- A note-on SHALL select the lowest-index non-busy voice.
- A note-off SHALL select the lowest-index busy voice whose tag equals the note.
REQ-007 The scan SHALL end on the first match, or after index NUM_VOICES-1, so it takes at most NUM_VOICES cycles.
REQ-008 On a note-off with no match, the FSM SHALL pulse ev_dropped, leave param_we at 0, and return to IDLE.
REQ-009 On a match, the FSM SHALL go to WAIT_GRANT and hold there until wr_grant=1 is sampled.
REQ-010 On a wr_grant hit, param_we SHALL be 1 for exactly the next cycle (WRITE state), with param_addr and param_data stable during that cycle.
REQ-011 Write contents:
- Note-on: gate=1, wave=ev_wave, delta_phase=note_to_delta_phase(note).
- Note-off: gate=0, wave=0, delta_phase=0.
REQ-012 The busy bit, tag and age SHALL update in the WRITE cycle, not before.
- Note-on: age=0 for the written voice; age+1, saturating at 255, for every other busy voice.
REQ-013 voices_active SHALL equal the popcount of the busy bits, registered, and SHALL update the cycle after WRITE.
REQ-014 A wr_grant pulse outside WAIT_GRANT SHALL be ignored.
REQ-015 A second note-on for a note already sounding SHALL allocate a further voice; there is no de-duplication.
REQ-016 delta_phase SHALL be table[note mod 12] >> (10 - note/12), using a logical shift and a 32-bit result.
- The table holds octave-10 values for fs=48 kHz.
- For notes 120..127 the shift is 0.

Reset
REQ-017 While reset=1: state=IDLE, all busy bits=0, tags=0, ages=0, param_we=0, param_addr=0, param_data=0, voices_active=0, ev_dropped=0, ev_ready=0.
REQ-018 Reset asserted mid-SCAN or mid-WAIT_GRANT SHALL abandon the pending event with no write.
REQ-019 Parameter RAM contents are not cleared by this block.

Configuration
REQ-020 Macro VOICE_ALLOCATOR_STEAL_EN SHALL control the behaviour of a note-on when no voice is free.
- Defined: steal the busy voice with the largest age, lowest index on ties, then proceed to WAIT_GRANT as a normal note-on.
- Defined: the steal search costs one extra NUM_VOICES-cycle pass.
- Undefined: pulse ev_dropped, make no write, and return to IDLE.

Structure
REQ-021 A shared package SHALL hold:
- the FSM state enum;
- the param_data field offsets (GATE_BIT=36, WAVE_MSB=35, WAVE_LSB=32);
- the 12-entry octave-10 delta_phase table.
REQ-022 SHALL instantiate one combinational sub-module, note_to_delta_phase (7-bit note in, 32-bit delta_phase out).

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Note-on 69, wave 2, into an empty allocator, grant 5 cycles later -> one param_we at addr 0, data {1,2,39370533}, voices_active=1.
- Note-on 60, then note-on 64 -> writes at addr 0 and addr 1; then note-off 60 -> write addr 0 with data 0, voices_active=1.
- Note-off 50 with no voice holding it -> ev_dropped pulses once, no param_we, ev_ready back to 1 within NUM_VOICES+1 cycles.
- 17 note-ons (notes 40..56) with NUM_VOICES=16:
  - with VOICE_ALLOCATOR_STEAL_EN: 17th event overwrites addr 0 (oldest) with note 56;
  - without it: ev_dropped pulses and voices_active stays 16.
- wr_grant pulsed while IDLE, then an event accepted -> no write until the next grant; exactly one param_we per event.
- Reset asserted during WAIT_GRANT -> no param_we, voices_active=0, next note-on lands at addr 0.
